planning_controller: RTL and testbench

Waypoint-following controller that closes the loop with the single-obstacle planning model. It drives `move_robot` and the one-hot `controllable_*` direction inputs, and tracks the robot position internally. It holds whenever the next cell is within one step of the obstacle. It sits on the controllable side of the synthesis benchmark and is the reference strategy the synthesized controller is checked against.

---
 rtl/planning_controller.sv | 166 ++++++++++++++++
 tb/tb_planning_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/planning_controller.sv
// planning_controller: waypoint-following reference strategy for the
// single-obstacle planning model. Tracks the robot position internally,
// requests one move per cycle along a fixed five-waypoint path and holds
// whenever the next cell lies within one step of the obstacle.
// Optional build macro PLANNER_STALL_EN adds the hold counter and the
// registered `stalled` flag; without it `stalled` is tied low.
module planning_controller #(
  parameter int K         = 2,
  parameter int STALL_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       end_init,
  input  logic       error,
  input  logic [3:0] obs1_x,
  input  logic [3:0] obs1_y,
  input  logic       _rt_robot,
  output logic       move_robot,
  output logic       controllable_up,
  output logic       controllable_down,
  output logic       controllable_left,
  output logic       controllable_right,
  output logic       done,
  output logic       stalled
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

  localparam logic [3:0] X_WALL = 4'(2 * K - 1);
  localparam logic [3:0] Y_MID  = 4'(2 * K);
  localparam logic [3:0] Y_LOW  = 4'(2 * K - 1);
  localparam logic [3:0] X_HI   = 4'(3 * K - 1);
  localparam logic [3:0] Y_HI   = 4'(3 * K - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] rx;
  logic [3:0] ry;
  logic [2:0] wp;
  logic [3:0] wx;
  logic [3:0] wy;
  logic       go_r;
  logic       go_l;
  logic       go_u;
  logic       go_d;
  logic [4:0] nx;
  logic [4:0] ny;
  logic       unsafe;
  logic       can_step;
  logic       commit;
  logic       reached;

  // Within one cell on an axis; operands widened to 5 bits so the
  // difference never wraps.
  function automatic logic near(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d <= 5'd1);
  endfunction

  // Current target waypoint.
  always_comb begin
    wx = X_HI;
    wy = Y_HI;
    case (wp)
      3'd0:    begin wx = 4'd0;   wy = Y_MID; end
      3'd1:    begin wx = X_WALL; wy = Y_MID; end
      3'd2:    begin wx = X_WALL; wy = Y_LOW; end
      3'd3:    begin wx = X_HI;   wy = Y_LOW; end
      default: begin wx = X_HI;   wy = Y_HI;  end
    endcase
  end

  // Direction toward the waypoint (segments are axis-aligned) and next cell.
  always_comb begin
    go_r = (rx < wx);
    go_l = (rx > wx);
    go_u = (rx == wx) && (ry < wy);
    go_d = (rx == wx) && (ry > wy);
    nx   = {1'b0, rx};
    ny   = {1'b0, ry};
    if (go_r)      nx = nx + 5'd1;
    else if (go_l) nx = nx - 5'd1;
    if (go_u)      ny = ny + 5'd1;
    else if (go_d) ny = ny - 5'd1;
  end

  assign unsafe   = near(nx, {1'b0, obs1_x}) && near(ny, {1'b0, obs1_y});
  assign can_step = (go_r | go_l | go_u | go_d) && !unsafe;
  assign commit   = (state == RUN) && can_step && _rt_robot;
  assign reached  = (nx[3:0] == wx) && (ny[3:0] == wy);

  // Next state and Mealy request outputs; error overrides everything.
  always_comb begin
    state_next         = state;
    move_robot         = 1'b0;
    controllable_up    = 1'b0;
    controllable_down  = 1'b0;
    controllable_left  = 1'b0;
    controllable_right = 1'b0;
    done               = 1'b0;
    case (state)
      IDLE: if (end_init) state_next = RUN;
      RUN: begin
        if (can_step) begin
          move_robot         = 1'b1;
          controllable_up    = go_u;
          controllable_down  = go_d;
          controllable_left  = go_l;
          controllable_right = go_r;
        end
        if (commit && reached && (wp == 3'd4)) state_next = DONE;
      end
      DONE:    done = 1'b1;
      default: state_next = FAIL;
    endcase
    if (error) state_next = FAIL;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Position and waypoint index advance on a committed move.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx <= 4'd0;
      ry <= 4'd0;
      wp <= 3'd0;
    end else if (commit && !error) begin
      rx <= nx[3:0];
      ry <= ny[3:0];
      if (reached && (wp != 3'd4)) wp <= wp + 3'd1;
    end
  end

`ifdef PLANNER_STALL_EN
  logic [7:0] hold_cnt;
  logic [7:0] hold_inc;
  logic       stalled_q;

  assign hold_inc = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
  assign stalled  = stalled_q;

  // Count consecutive hold cycles; a committed move restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= 8'd0;
      stalled_q <= 1'b0;
    end else if (error || state == FAIL) begin
      stalled_q <= 1'b0;
    end else if (commit) begin
      hold_cnt  <= 8'd0;
      stalled_q <= 1'b0;
    end else if ((state == RUN) && !can_step) begin
      hold_cnt  <= hold_inc;
      stalled_q <= (hold_inc >= 8'(STALL_MAX));
    end
  end
`else
  assign stalled = 1'b0;
`endif

endmodule

// File: tb/tb_planning_controller.sv
// Bench for planning_controller (K=2, STALL_MAX=64): a cycle table covering
// holds, withheld ticks and the full path, then hand-written sequences for
// the nominal run, stall, error and mid-run reset.
module tb_planning_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       end_init = 1'b0;
  logic       error = 1'b0;
  logic       rt_robot = 1'b0;
  logic [3:0] ox = 4'd5;
  logic [3:0] oy = 4'd0;
  logic       move_robot;
  logic       c_up;
  logic       c_down;
  logic       c_left;
  logic       c_right;
  logic       done;
  logic       stalled;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PLANNER_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  // Output vector: {move, up, down, left, right, done, stalled}
  localparam logic [6:0] O_Z    = 7'b0000000;
  localparam logic [6:0] O_U    = 7'b1100000;
  localparam logic [6:0] O_D    = 7'b1010000;
  localparam logic [6:0] O_R    = 7'b1000100;
  localparam logic [6:0] O_DONE = 7'b0000010;

  typedef struct {
    logic [3:0] ox;
    logic [3:0] oy;
    logic       rt;
    logic [6:0] want;
  } vec_t;

  vec_t       vecs[23];
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  planning_controller #(.K(2), .STALL_MAX(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .end_init           (end_init),
    .error              (error),
    .obs1_x             (ox),
    .obs1_y             (oy),
    ._rt_robot          (rt_robot),
    .move_robot         (move_robot),
    .controllable_up    (c_up),
    .controllable_down  (c_down),
    .controllable_left  (c_left),
    .controllable_right (c_right),
    .done               (done),
    .stalled            (stalled)
  );

  function automatic logic [6:0] outs();
    return {move_robot, c_up, c_down, c_left, c_right, done, stalled};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_cycle(input string name, input logic [6:0] want);
    @(negedge clk);
    chk(name, 32'(outs()), 32'(want));
    next_cycle();
  endtask

  task automatic apply_reset(input string name);
    rst = 1'b1; end_init = 1'b0; error = 1'b0; rt_robot = 1'b0;
    next_cycle();
    @(negedge clk);
    chk(name, 32'(outs()), 32'(O_Z));
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic start_run();
    end_init = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'(outs()), 32'(O_Z));
    next_cycle();
    end_init = 1'b0;
  endtask

  // Full path with obstacle clear: 12 requests, then done, end_init ignored.
  task automatic run_nominal(input string tag);
    logic [6:0] path[12];
    int         nreq;
    logic [6:0] want;
    path = '{O_U, O_U, O_U, O_U, O_R, O_R, O_R, O_D, O_R, O_R, O_U, O_U};
    exp_q.delete();
    foreach (path[i]) exp_q.push_back(path[i]);
    ox = 4'd5; oy = 4'd0; rt_robot = 1'b1;
    nreq = 0;
    for (int c = 0; c < 18; c++) begin
      end_init = (c == 15);
      @(negedge clk);
      if (move_robot) nreq++;
      if (exp_q.size() != 0) want = exp_q.pop_front();
      else                   want = O_DONE;
      chk($sformatf("%s_cycle%0d", tag, c), 32'(outs()), 32'(want));
      next_cycle();
    end
    end_init = 1'b0;
    chk({tag, "_request_count"}, 32'(nreq), 32'd12);
  endtask

  initial begin
    // ox, oy, rt, expected outputs during that cycle
    vecs[0]  = '{4'd0, 4'd5, 1'b1, O_U};
    vecs[1]  = '{4'd0, 4'd5, 1'b1, O_U};
    vecs[2]  = '{4'd0, 4'd5, 1'b1, O_U};    // now at (0,3)
    vecs[3]  = '{4'd0, 4'd5, 1'b1, O_Z};    // (0,4) next to obstacle
    vecs[4]  = '{4'd0, 4'd5, 1'b1, O_Z};
    vecs[5]  = '{4'd5, 4'd0, 1'b0, O_U};    // cleared, tick withheld x5
    vecs[6]  = '{4'd5, 4'd0, 1'b0, O_U};
    vecs[7]  = '{4'd5, 4'd0, 1'b0, O_U};
    vecs[8]  = '{4'd5, 4'd0, 1'b0, O_U};
    vecs[9]  = '{4'd5, 4'd0, 1'b0, O_U};
    vecs[10] = '{4'd5, 4'd0, 1'b1, O_U};    // -> (0,4)
    vecs[11] = '{4'd5, 4'd0, 1'b1, O_R};    // -> (1,4)
    vecs[12] = '{4'd5, 4'd0, 1'b0, O_R};
    vecs[13] = '{4'd4, 4'd5, 1'b1, O_R};    // dx=2 dy=1: safe, -> (2,4)
    vecs[14] = '{4'd5, 4'd0, 1'b1, O_R};    // -> (3,4)
    vecs[15] = '{4'd5, 4'd0, 1'b1, O_D};    // -> (3,3)
    vecs[16] = '{4'd5, 4'd0, 1'b1, O_R};    // -> (4,3)
    vecs[17] = '{4'd4, 4'd2, 1'b1, O_Z};    // diagonal neighbour of (5,3)
    vecs[18] = '{4'd5, 4'd0, 1'b1, O_R};    // -> (5,3)
    vecs[19] = '{4'd5, 4'd0, 1'b1, O_U};    // -> (5,4)
    vecs[20] = '{4'd5, 4'd0, 1'b1, O_U};    // -> (5,5)
    vecs[21] = '{4'd5, 4'd0, 1'b1, O_DONE};
    vecs[22] = '{4'd4, 4'd4, 1'b1, O_DONE};

    // Table-driven run: holds, withheld ticks and full path
    apply_reset("reset_outputs");
    start_run();
    foreach (vecs[i]) begin
      ox = vecs[i].ox; oy = vecs[i].oy; rt_robot = vecs[i].rt;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].want));
      next_cycle();
    end

    // Nominal run
    apply_reset("nominal_reset");
    start_run();
    run_nominal("nominal");

    // Stall: obstacle parked at (0,5) for 70 hold cycles
    apply_reset("stall_reset");
    start_run();
    ox = 4'd0; oy = 4'd5; rt_robot = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle("stall_approach", O_U);
    for (int h = 1; h <= 70; h++)
      expect_cycle($sformatf("stall_hold%0d", h), {6'b0, (STALL_ON && (h > 64))});
    ox = 4'd5; oy = 4'd0;
    expect_cycle("stall_resume", O_U | 7'(STALL_ON));
    expect_cycle("stall_clear", O_R);

    // Error: FAIL from the next edge, end_init ignored
    apply_reset("error_reset");
    start_run();
    ox = 4'd5; oy = 4'd0; rt_robot = 1'b1;
    for (int i = 0; i < 3; i++) expect_cycle("error_pre", O_U);
    error = 1'b1;
    expect_cycle("error_same_cycle", O_U);
    error = 1'b0;
    expect_cycle("fail_outputs", O_Z);
    expect_cycle("fail_outputs", O_Z);
    end_init = 1'b1;
    expect_cycle("fail_ignores_end_init", O_Z);
    end_init = 1'b0;
    expect_cycle("fail_stays", O_Z);

    // Recovery after rst, then reset mid-run after 6 moves
    apply_reset("recover_reset");
    start_run();
    ox = 4'd5; oy = 4'd0; rt_robot = 1'b1;
    expect_cycle("recover_first", O_U);
    for (int i = 0; i < 3; i++) expect_cycle("midrun_up", O_U);
    for (int i = 0; i < 2; i++) expect_cycle("midrun_right", O_R);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("midrun_in_reset", 32'(outs()), 32'(O_Z));
    next_cycle();
    rst = 1'b0;
    expect_cycle("midrun_idle", O_Z);
    expect_cycle("midrun_idle", O_Z);
    start_run();
    run_nominal("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
